// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the HDMI transmit path.
// Produces HS/VS/DE and pixel coordinates with all outputs registered and
// describing the same (x_counter, y_counter) in every cycle.
// Optional build macro VIDEO_TIMING_PATTERN_EN adds HDMI_TX_D colour bars.
//
// state      | meaning (same encoding for horizontal and vertical FSMs)
// ST_ACTIVE  | counter inside the active (visible) range
// ST_FRONT   | counter inside the front porch
// ST_SYNC    | counter inside the sync pulse; sync output asserted
// ST_BACK    | counter inside the back porch, up to total-1
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        HDMI_TX_CLK,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic        HDMI_TX_HS,
  output logic        HDMI_TX_VS,
  output logic        HDMI_TX_DE,
  output logic [11:0] x_counter,
  output logic [11:0] y_counter,
  output logic        line_start,
  output logic        frame_start
`ifdef VIDEO_TIMING_PATTERN_EN
  ,
  output logic [23:0] HDMI_TX_D
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
      $error("video_timing_gen: every horizontal parameter must be at least 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
      $error("video_timing_gen: every vertical parameter must be at least 1");
    end
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("video_timing_gen: horizontal and vertical totals must not exceed 4095");
    end
  endgenerate

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_FP_START = 12'(H_ACTIVE);
  localparam logic [11:0] H_SY_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_BP_START = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_FP_START = 12'(V_ACTIVE);
  localparam logic [11:0] V_SY_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_BP_START = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON      = (HS_POL != 0);
  localparam logic        VS_ON      = (VS_POL != 0);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} state_t;

  logic [11:0] r_x, r_y;
  state_t      r_hstate, r_vstate;
  logic        r_hs, r_vs, r_de, r_ls, r_fs;

  logic        w_x_wrap;
  logic [11:0] w_x_nxt, w_y_nxt;
  state_t      w_hstate_nxt, w_vstate_nxt;
  logic        w_de_nxt;

  // Next pixel position: x wraps at H_TOTAL-1, y steps only on an x wrap.
  always_comb begin
    w_x_wrap = (r_x == H_LAST);
    w_x_nxt  = w_x_wrap ? 12'd0 : r_x + 12'd1;
    w_y_nxt  = r_y;
    if (w_x_wrap) begin
      w_y_nxt = (r_y == V_LAST) ? 12'd0 : r_y + 12'd1;
    end
  end

  // Next-state logic for both FSMs, keyed on the counter entering a new range.
  always_comb begin
    w_hstate_nxt = r_hstate;
    w_vstate_nxt = r_vstate;
    case (r_hstate)
      ST_ACTIVE: if (w_x_nxt == H_FP_START) w_hstate_nxt = ST_FRONT;
      ST_FRONT:  if (w_x_nxt == H_SY_START) w_hstate_nxt = ST_SYNC;
      ST_SYNC:   if (w_x_nxt == H_BP_START) w_hstate_nxt = ST_BACK;
      ST_BACK:   if (w_x_nxt == 12'd0)      w_hstate_nxt = ST_ACTIVE;
      default:   w_hstate_nxt = ST_BACK;
    endcase
    if (w_x_wrap) begin
      case (r_vstate)
        ST_ACTIVE: if (w_y_nxt == V_FP_START) w_vstate_nxt = ST_FRONT;
        ST_FRONT:  if (w_y_nxt == V_SY_START) w_vstate_nxt = ST_SYNC;
        ST_SYNC:   if (w_y_nxt == V_BP_START) w_vstate_nxt = ST_BACK;
        ST_BACK:   if (w_y_nxt == 12'd0)      w_vstate_nxt = ST_ACTIVE;
        default:   w_vstate_nxt = ST_BACK;
      endcase
    end
    w_de_nxt = (w_hstate_nxt == ST_ACTIVE) && (w_vstate_nxt == ST_ACTIVE);
  end

  // FSM state registers; reset parks both in the back porch at total-1.
  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      r_hstate <= ST_BACK;
      r_vstate <= ST_BACK;
    end else if (pix_ce) begin
      r_hstate <= w_hstate_nxt;
      r_vstate <= w_vstate_nxt;
    end
  end

  // Position counters; reset puts them one pixel before (0,0).
  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      r_x <= H_LAST;
      r_y <= V_LAST;
    end else if (pix_ce) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  // Output registers, loaded from next-state values so they line up with the counters.
  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      r_hs <= ~HS_ON;
      r_vs <= ~VS_ON;
      r_de <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (pix_ce) begin
      r_hs <= (w_hstate_nxt == ST_SYNC) ? HS_ON : ~HS_ON;
      r_vs <= (w_vstate_nxt == ST_SYNC) ? VS_ON : ~VS_ON;
      r_de <= w_de_nxt;
      r_ls <= (w_x_nxt == 12'd0);
      r_fs <= (w_x_nxt == 12'd0) && (w_y_nxt == 12'd0);
    end
  end

  assign HDMI_TX_HS  = r_hs;
  assign HDMI_TX_VS  = r_vs;
  assign HDMI_TX_DE  = r_de;
  assign x_counter   = r_x;
  assign y_counter   = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam int          BAR_W   = H_ACTIVE / 8;
  localparam logic [11:0] BAR_DIV = 12'((BAR_W == 0) ? 1 : BAR_W);

  logic [11:0] w_bar;
  logic [23:0] w_rgb;
  logic [23:0] r_rgb;

  // Colour for the next pixel; columns beyond the eighth bar stay black.
  always_comb begin
    w_bar = w_x_nxt / BAR_DIV;
    w_rgb = 24'h000000;
    if (BAR_W != 0) begin
      case (w_bar)
        12'd0:   w_rgb = 24'hFFFFFF;
        12'd1:   w_rgb = 24'hFFFF00;
        12'd2:   w_rgb = 24'h00FFFF;
        12'd3:   w_rgb = 24'h00FF00;
        12'd4:   w_rgb = 24'hFF00FF;
        12'd5:   w_rgb = 24'hFF0000;
        12'd6:   w_rgb = 24'h0000FF;
        default: w_rgb = 24'h000000;
      endcase
    end
  end

  // Pixel data register, forced to zero outside the active area.
  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      r_rgb <= 24'h000000;
    end else if (pix_ce) begin
      r_rgb <= w_de_nxt ? w_rgb : 24'h000000;
    end
  end

  assign HDMI_TX_D = r_rgb;
`endif

endmodule
